// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the decode-to-execute boundary: load-use
// stalls, multi-cycle multiply sequencing, branch flush and perf counters.
module hazard_ctrl #(
   parameter int MUL_LAT = 4,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       D_rs1,
   input  logic [4:0]       D_rs2,
   input  logic             D_use_rs1,
   input  logic             D_use_rs2,
   input  logic [4:0]       EX_rd,
   input  logic             EX_ld,
   input  logic             EX_mul,
   input  logic             EX_taken,
   output logic             stall_F,
   output logic             stall_D,
   output logic             flush_F,
   output logic             mul_start,
   output logic             mul_done,
   output logic             mul_busy,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic {RUN, MUL_WAIT} state_t;

   // Remaining stall cycles after the start cycle; MUL_LAT <= 16 keeps this in 4 bits.
   localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 2);

   state_t     state;
   logic [3:0] cnt;
   logic       load_use;
   logic       in_run;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      load_use  = 1'b0;
      in_run    = (state == RUN);
      mul_start = 1'b0;
      mul_busy  = 1'b0;
      mul_done  = 1'b0;
      stall_D   = 1'b0;
      flush_F   = 1'b0;

      if (EX_ld && (EX_rd != 5'd0) &&
          ((D_use_rs1 && (D_rs1 == EX_rd)) || (D_use_rs2 && (D_rs2 == EX_rd))))
         load_use = 1'b1;

      if (in_run) begin
         mul_start = EX_mul;
         stall_D   = load_use || EX_mul;
         flush_F   = EX_taken;
      end else begin
         // EX holds a bubble while waiting, so its inputs are not consulted here.
         mul_busy = 1'b1;
         mul_done = (cnt == 4'd0);
         stall_D  = (cnt != 4'd0);
      end

      // A redirect must let the new fetch through even when D is stalled.
      stall_F = stall_D && !flush_F;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         cnt       <= 4'd0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         case (state)
            RUN: begin
               if (EX_mul) begin
                  state <= MUL_WAIT;
                  cnt   <= CNT_LOAD;
               end
            end
            MUL_WAIT: begin
               if (cnt == 4'd0)
                  state <= RUN;
               else
                  cnt <= cnt - 4'd1;
            end
            default: begin
               state <= RUN;
               cnt   <= 4'd0;
            end
         endcase

         if (stall_D && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_F && (flush_cnt != {CNT_W{1'b1}}))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule
